// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
//   rx_entry_t  : one FIFO entry, the received byte plus its framing status
//   rxa_state_e : frame-assembly state of rx_byte_assembler
//   UART_DATA_BITS : data bits per frame
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef struct packed {
    logic                      frame_err;
    logic [UART_DATA_BITS-1:0] data;
  } rx_entry_t;

  typedef enum logic {
    RXA_IDLE,
    RXA_ASSEMBLE
  } rxa_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead FIFO of rx_entry_t for the receive byte assembler.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears pointers and storage)
//   push         write push_entry when there is room (or when a pop frees room this cycle)
//   push_entry   entry to store
//   pop          remove the head entry; ignored while empty
//   head         entry at the read pointer, valid whenever empty is low
//   empty        no entries stored
//   drop         push requested while full with no pop: entry discarded
//   level        (only with RX_FIFO_LEVEL_EN) current number of entries
// Pointers carry one extra MSB so full and empty are distinguished without a counter.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  rx_entry_t push_entry,
  input  logic      pop,
  output rx_entry_t head,
  output logic      empty,
`ifdef RX_FIFO_LEVEL_EN
  output logic [AW:0] level,
`endif
  output logic      drop
);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rx_entry_t   mem_q [DEPTH];
  rx_entry_t   mem_d [DEPTH];
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when the head is being consumed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign head = mem_q[rd_ptr_q[AW-1:0]];

`ifdef RX_FIFO_LEVEL_EN
  assign level = wr_ptr_q - rd_ptr_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_entry;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/rx_byte_assembler.sv
// Receive byte assembler: deserialises data bits (LSB first) from the bit
// detector, tags each completed byte with its framing status and buffers it
// in a show-ahead FIFO for the host.
// Optional feature macro: RX_FIFO_LEVEL_EN adds the fifo_level output.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   active_rx           bit detector is inside a frame
//   bit_ready, rx_bit   one-cycle strobe qualifying the next data bit
//   framing_err, done   end-of-frame strobe and its stop-bit status
//   data_out, data_out_frame_err, data_out_valid, data_out_ready  host interface
//   overrun, overrun_clr  sticky drop flag and its clear pulse
//   rx_busy             a frame is being assembled
//   fifo_level          (RX_FIFO_LEVEL_EN) number of queued entries
//   dbg_state           frame-assembly state, for observation only
// Host handshake: data_out/data_out_frame_err are valid while data_out_valid
// is high and stay stable until the cycle data_out_valid && data_out_ready is
// seen at a rising edge, which consumes the entry; ready while not valid has
// no effect.
module rx_byte_assembler
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 active_rx,
  input  logic                 bit_ready,
  input  logic                 rx_bit,
  input  logic                 framing_err,
  input  logic                 done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_frame_err,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 rx_busy,
`ifdef RX_FIFO_LEVEL_EN
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`endif
  output rxa_state_e           dbg_state
);

  localparam int CW = $clog2(DATA_BITS + 1);

  rxa_state_e           state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 active_rx_q, active_rx_d;
  logic                 push_q, push_d;
  rx_entry_t            entry_q, entry_d;
  logic                 overrun_q, overrun_d;

  logic [DATA_BITS-1:0] shift_val;
  logic [CW-1:0]        cnt_val;
  rx_entry_t            head;
  logic                 fifo_empty;
  logic                 fifo_drop;

  // Value of the shift register / counter including this cycle's bit, so a
  // bit arriving together with done still makes it into the pushed byte.
  assign shift_val = bit_ready ? {rx_bit, shreg_q[DATA_BITS-1:1]} : shreg_q;
  assign cnt_val   = (bit_ready && (bit_cnt_q != CW'(DATA_BITS))) ?
                     bit_cnt_q + CW'(1) : bit_cnt_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shift_val;
    bit_cnt_d   = cnt_val;
    active_rx_d = active_rx;
    push_d      = done;
    entry_d     = entry_q;
    if (done) begin
      // Frame complete: capture the entry; it is written to the FIFO next cycle.
      entry_d.data      = shift_val;
      entry_d.frame_err = framing_err | (cnt_val != CW'(DATA_BITS));
      shreg_d           = '0;
      bit_cnt_d         = '0;
      state_d           = RXA_IDLE;
    end else if ((state_q == RXA_ASSEMBLE) && active_rx_q && !active_rx) begin
      // Detector left the frame without an end strobe: discard partial byte.
      shreg_d   = '0;
      bit_cnt_d = '0;
      state_d   = RXA_IDLE;
    end else if (bit_ready) begin
      state_d = RXA_ASSEMBLE;
    end
  end

  // Set has priority over clear so a drop coinciding with a clear is not lost.
  assign overrun_d = (overrun_q & ~overrun_clr) | fifo_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RXA_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      active_rx_q <= 1'b0;
      push_q      <= 1'b0;
      entry_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      active_rx_q <= active_rx_d;
      push_q      <= push_d;
      entry_q     <= entry_d;
      overrun_q   <= overrun_d;
    end
  end

  rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_q),
    .push_entry (entry_q),
    .pop        (data_out_ready),
    .head       (head),
    .empty      (fifo_empty),
`ifdef RX_FIFO_LEVEL_EN
    .level      (fifo_level),
`endif
    .drop       (fifo_drop)
  );

  assign data_out           = head.data;
  assign data_out_frame_err = head.frame_err;
  assign data_out_valid     = !fifo_empty;
  assign overrun            = overrun_q;
  assign rx_busy            = (state_q == RXA_ASSEMBLE);
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Testbench for rx_byte_assembler: directed boundary scenarios followed by
// randomized frames, checked through an expected-entry queue and a monitor.
module tb_rx_byte_assembler;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       active_rx, bit_ready, rx_bit, framing_err, done;
  logic [7:0] data_out;
  logic       data_out_frame_err, data_out_valid, data_out_ready;
  logic       overrun, overrun_clr, rx_busy;
`ifdef RX_FIFO_LEVEL_EN
  logic [2:0] fifo_level;
`endif
  uart_pkg::rxa_state_e dbg_state;

  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         rand_ready = 1'b0;

  always #5 clk = ~clk;

  rx_byte_assembler #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .active_rx          (active_rx),
    .bit_ready          (bit_ready),
    .rx_bit             (rx_bit),
    .framing_err        (framing_err),
    .done               (done),
    .data_out           (data_out),
    .data_out_frame_err (data_out_frame_err),
    .data_out_valid     (data_out_valid),
    .data_out_ready     (data_out_ready),
    .overrun            (overrun),
    .overrun_clr        (overrun_clr),
    .rx_busy            (rx_busy),
`ifdef RX_FIFO_LEVEL_EN
    .fifo_level         (fifo_level),
`endif
    .dbg_state          (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Reference: the first n data bits (LSB first) of b end up in the top n
  // bit positions of the byte; anything other than a full 8 bits is flagged.
  function automatic logic [8:0] model_entry(input logic [7:0] b, input int n, input logic ferr);
    logic [7:0] d;
    d = 8'(b << (8 - n));
    return {ferr | (n != 8), d};
  endfunction

  task automatic expect_frame(input logic [7:0] b, input int n, input logic ferr);
    exp_q.push_back(model_entry(b, n, ferr));
  endtask

  // ---------------- clock/reset helpers and driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) data_out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Returns one step after the edge that sampled done, i.e. inside the push cycle.
  task automatic send_frame(input logic [7:0] b, input int n, input logic ferr, input bit done_on_bit);
    active_rx = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit_ready = 1'b1;
      rx_bit    = b[i];
      if (i == n - 1 && done_on_bit) begin
        done        = 1'b1;
        framing_err = ferr;
      end
      tick();
      bit_ready = 1'b0;
      rx_bit    = 1'b0;
      if (i == n - 1 && done_on_bit) begin
        done        = 1'b0;
        framing_err = 1'b0;
        active_rx   = 1'b0;
        return;
      end
      repeat ($urandom_range(0, 1)) tick();
    end
    done        = 1'b1;
    framing_err = ferr;
    tick();
    done        = 1'b0;
    framing_err = 1'b0;
    active_rx   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    tick();
    data_out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      tick();
      guard++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    tick();
    @(negedge clk);
    chk({name, "_empty_valid"}, data_out_valid, 0);
    tick();
    data_out_ready = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && data_out_valid && data_out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got %0h with nothing expected",
                 {data_out_frame_err, data_out});
      end else begin
        chk("fifo_head", {data_out_frame_err, data_out}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; active_rx = 0; bit_ready = 0; rx_bit = 0; framing_err = 0;
    done = 0; data_out_ready = 0; overrun_clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out", data_out, 0);
    chk("reset_valid", data_out_valid, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", rx_busy, 0);
`ifdef RX_FIFO_LEVEL_EN
    chk("reset_level", fifo_level, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // 1: 8'hA5, valid exactly two cycles after done
    expect_frame(8'hA5, 8, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_valid_1clk", data_out_valid, 0);
    @(negedge clk);
    chk("t1_valid_2clk", data_out_valid, 1);
    chk("t1_data", data_out, 8'hA5);
    chk("t1_ferr", data_out_frame_err, 0);
    wait_drain("t1");

    // 2: framing error flagged on a full byte
    expect_frame(8'h3C, 8, 1'b1);
    send_frame(8'h3C, 8, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_data", data_out, 8'h3C);
    chk("t2_ferr", data_out_frame_err, 1);
    wait_drain("t2");

    // 3: overflow drops the fifth byte; clear behaviour including set-wins
    for (int k = 1; k <= 5; k++) begin
      if (k <= DEPTH) expect_frame(8'(k), 8, 1'b0);
      send_frame(8'(k), 8, 1'b0, bit'($urandom_range(0, 1)));
      tick();
    end
    repeat (2) tick();
    @(negedge clk);
    chk("t3_overrun_set", overrun, 1);
    chk("t3_valid_full", data_out_valid, 1);
`ifdef RX_FIFO_LEVEL_EN
    chk("t3_level_full", fifo_level, DEPTH);
`endif
    tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    @(negedge clk);
    chk("t3_overrun_cleared", overrun, 0);
    send_frame(8'h06, 8, 1'b0, 1'b0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    @(negedge clk);
    chk("t3_set_wins_over_clr", overrun, 1);
    tick();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    @(negedge clk);
    chk("t3_overrun_cleared2", overrun, 0);
    wait_drain("t3");

    // 4: push into a full FIFO while the head is popped
    for (int k = 0; k < DEPTH; k++) begin
      expect_frame(8'h10 + 8'(k), 8, 1'b0);
      send_frame(8'h10 + 8'(k), 8, 1'b0, 1'b0);
      tick();
    end
    expect_frame(8'h14, 8, 1'b0);
    send_frame(8'h14, 8, 1'b0, 1'b0);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    @(negedge clk);
    chk("t4_no_overrun", overrun, 0);
`ifdef RX_FIFO_LEVEL_EN
    chk("t4_level", fifo_level, DEPTH);
`endif
    wait_drain("t4");

    // 5: aborted frame leaves no residue
    active_rx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit_ready = 1'b1;
      rx_bit    = 1'b1;
      tick();
      bit_ready = 1'b0;
    end
    @(negedge clk);
    chk("t5_busy", rx_busy, 1);
    tick();
    active_rx = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_idle_after_abort", rx_busy, 0);
    chk("t5_nothing_pushed", data_out_valid, 0);
    expect_frame(8'h15, 5, 1'b0);
    send_frame(8'h15, 5, 1'b0, 1'b1);
    tick();
    expect_frame(8'hFF, 8, 1'b0);
    send_frame(8'hFF, 8, 1'b0, 1'b0);
    wait_drain("t5");

    // 6: reset with two entries queued, overrun set and a frame in progress
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (k < DEPTH) expect_frame(8'h20 + 8'(k), 8, 1'b0);
      send_frame(8'h20 + 8'(k), 8, 1'b0, 1'b0);
      tick();
    end
    tick();
    data_out_ready = 1'b1;
    repeat (2) tick();
    data_out_ready = 1'b0;
    active_rx = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bit_ready = 1'b1;
      rx_bit    = 1'b1;
      tick();
      bit_ready = 1'b0;
    end
    @(negedge clk);
    chk("t6_pre_overrun", overrun, 1);
    chk("t6_pre_valid", data_out_valid, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", data_out_valid, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_busy", rx_busy, 0);
    chk("t6_rst_data", data_out, 0);
`ifdef RX_FIFO_LEVEL_EN
    chk("t6_rst_level", fifo_level, 0);
`endif
    exp_q.delete();
    active_rx = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    expect_frame(8'h5A, 8, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0);
    wait_drain("t6_post");

    // Randomized frames with random host backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      logic [7:0] b;
      int         n;
      logic       ferr;
      int         guard;
      guard = 0;
      while (exp_q.size() >= DEPTH - 1 && guard < 200) begin
        tick();
        guard++;
      end
      if (guard >= 200) begin
        n_checks++;
        $display("FAIL rand_backpressure: queue stuck at %0d entries", exp_q.size());
      end
      b    = 8'($urandom_range(0, 255));
      n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 7)) : 8;
      ferr = ($urandom_range(0, 4) == 0);
      expect_frame(b, n, ferr);
      send_frame(b, n, ferr, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 1'b0;
    wait_drain("rand");
    @(negedge clk);
    chk("final_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
